// File: rtl/priority_encoder_32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// priority_encoder_32 : registered 32-bit leading-one encoder (index + zero)
// Revision: 1.0
// ---------------------------------------------------------------------------

// 4-bit leaf: valid when any bit is set, idx is the highest set position.
module pe32_leaf4 (
  input  logic [3:0] d,
  output logic       valid,
  output logic [1:0] idx
);

  always_comb begin
    valid = |d;
    idx   = 2'd0;
    if (d[3]) begin
      idx = 2'd3;
    end else if (d[2]) begin
      idx = 2'd2;
    end else if (d[1]) begin
      idx = 2'd1;
    end
  end

endmodule

// Merge two sibling nodes; the upper half wins whenever it holds a set bit.
module pe32_merge #(
  parameter int SUB_W = 2
) (
  input  logic             valid_hi,
  input  logic [SUB_W-1:0] idx_hi,
  input  logic             valid_lo,
  input  logic [SUB_W-1:0] idx_lo,
  output logic             valid,
  output logic [SUB_W:0]   idx
);

  always_comb begin
    valid = valid_hi | valid_lo;
    idx   = valid_hi ? {1'b1, idx_hi} : {1'b0, idx_lo};
  end

endmodule

module priority_encoder_32 (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data,
  output logic [4:0]  index,
  output logic        zero
);

  localparam int c_LEAVES = 8;

  logic [c_LEAVES-1:0] l0_valid;
  logic [1:0]          l0_idx [c_LEAVES];
  logic [3:0]          l1_valid;
  logic [2:0]          l1_idx [4];
  logic [1:0]          l2_valid;
  logic [3:0]          l2_idx [2];
  logic                l3_valid;
  logic [4:0]          l3_idx;

  logic [4:0] index_d;
  logic [4:0] index_q;
  logic       zero_d;
  logic       zero_q;

  generate
    for (genvar g = 0; g < c_LEAVES; g++) begin : g_leaf
      pe32_leaf4 u_leaf (
        .d     (data[4*g +: 4]),
        .valid (l0_valid[g]),
        .idx   (l0_idx[g])
      );
    end

    for (genvar g = 0; g < 4; g++) begin : g_merge8
      pe32_merge #(.SUB_W(2)) u_merge (
        .valid_hi (l0_valid[2*g+1]),
        .idx_hi   (l0_idx[2*g+1]),
        .valid_lo (l0_valid[2*g]),
        .idx_lo   (l0_idx[2*g]),
        .valid    (l1_valid[g]),
        .idx      (l1_idx[g])
      );
    end

    for (genvar g = 0; g < 2; g++) begin : g_merge16
      pe32_merge #(.SUB_W(3)) u_merge (
        .valid_hi (l1_valid[2*g+1]),
        .idx_hi   (l1_idx[2*g+1]),
        .valid_lo (l1_valid[2*g]),
        .idx_lo   (l1_idx[2*g]),
        .valid    (l2_valid[g]),
        .idx      (l2_idx[g])
      );
    end
  endgenerate

  pe32_merge #(.SUB_W(4)) u_merge32 (
    .valid_hi (l2_valid[1]),
    .idx_hi   (l2_idx[1]),
    .valid_lo (l2_valid[0]),
    .idx_lo   (l2_idx[0]),
    .valid    (l3_valid),
    .idx      (l3_idx)
  );

  // All-zero data falls through every lower branch to index 0.
  always_comb begin
    index_d = l3_idx;
    zero_d  = ~l3_valid;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      index_q <= 5'd0;
      zero_q  <= 1'b1;
    end else begin
      index_q <= index_d;
      zero_q  <= zero_d;
    end
  end

  assign index = index_q;
  assign zero  = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_priority_encoder_32 : directed self-checking bench for priority_encoder_32
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_priority_encoder_32;

  logic        clock;
  logic        reset;
  logic [31:0] data;
  logic [4:0]  index;
  logic        zero;

  int n_checks = 0;
  int n_errors = 0;
  int prev_idx = 0;
  int prev_zero = 1;

  priority_encoder_32 u_dut (
    .clock (clock),
    .reset (reset),
    .data  (data),
    .index (index),
    .zero  (zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive on the falling edge, confirm outputs hold until the next rising
  // edge, then check the registered result just after it.
  task automatic step(input logic [31:0] v, input logic rst, input int exp_idx,
                      input int exp_zero, input string tag);
    @(negedge clock);
    data  = v;
    reset = rst;
    #1;
    check({tag, " hold idx"},  int'(index), prev_idx);
    check({tag, " hold zero"}, int'(zero),  prev_zero);
    @(posedge clock);
    #1;
    check({tag, " idx"},  int'(index), exp_idx);
    check({tag, " zero"}, int'(zero),  exp_zero);
    prev_idx  = exp_idx;
    prev_zero = exp_zero;
  endtask

  initial begin
    reset = 1'b1;
    data  = 32'hFFFF_FFFF;
    repeat (2) begin
      @(posedge clock);
      #1;
      check("reset idx",  int'(index), 0);
      check("reset zero", int'(zero),  1);
    end

    step(32'hFFFF_FFFF, 1'b0, 31, 0, "release");

    // Thermometer sweep
    step(32'h0000_0000, 1'b0, 0, 1, "therm0");
    for (int i = 1; i <= 32; i++) begin
      step(32'hFFFF_FFFF >> (32 - i), 1'b0, i - 1, 0, $sformatf("therm%0d", i));
    end

    // One-hot sweep
    for (int k = 0; k < 32; k++) begin
      step(32'h1 << k, 1'b0, k, 0, $sformatf("onehot%0d", k));
    end
    step(32'h0000_0000, 1'b0, 0, 1, "zero_vs_bit0");
    step(32'h0000_0001, 1'b0, 0, 0, "bit0_vs_zero");

    // Priority over lower bits
    step(32'h8000_0001, 1'b0, 31, 0, "prio_8000_0001");
    step(32'h0001_FFFF, 1'b0, 16, 0, "prio_0001_FFFF");
    step(32'h0000_0300, 1'b0, 9,  0, "prio_0000_0300");
    step(32'h0000_00FF, 1'b0, 7,  0, "prio_0000_00FF");
    step(32'h0000_0080, 1'b0, 7,  0, "prio_0000_0080");
    step(32'h0F0F_0F0F, 1'b0, 27, 0, "prio_0F0F_0F0F");

    // Back-to-back streaming
    step(32'h0000_0000, 1'b0, 0,  1, "stream0");
    step(32'h0000_0010, 1'b0, 4,  0, "stream1");
    step(32'hFFFF_FFFF, 1'b0, 31, 0, "stream2");
    step(32'h0000_0001, 1'b0, 0,  0, "stream3");
    step(32'h4000_0000, 1'b0, 30, 0, "stream4");

    // Reset mid-stream
    step(32'h0001_0000, 1'b1, 0,  1, "midreset");
    step(32'h0001_0000, 1'b0, 16, 0, "resume");
    step(32'h0000_0040, 1'b0, 6,  0, "resume2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
